// File: rtl/cdb_arbiter_rr_pkg.sv
// cdb_arbiter_rr_pkg: shared sizing, packet types and helpers for the completion bus
// Contents: default FU counts, port count, queue depth, field widths,
//   CDB request / broadcast / ROB completion packet types and their flat widths.
package cdb_arbiter_rr_pkg;
  localparam int NUM_FU_ALU  = 2;
  localparam int NUM_FU_MULT = 1;
  localparam int NUM_FU_LOAD = 1;
  localparam int N           = 2;
  localparam int CDB_QDEPTH  = 2;
  localparam int PRN_W       = 6;
  localparam int ROB_W       = 5;
  localparam int XLEN        = 32;
  typedef struct packed {
    logic [ROB_W-1:0] robn;
    logic [PRN_W-1:0] dest_prn;
    logic [XLEN-1:0]  value;
    logic             take_branch;
    logic [XLEN-1:0]  target_addr;
  } cdb_req_packet_t;
  typedef struct packed {
    logic [PRN_W-1:0] dest_prn;
    logic [XLEN-1:0]  value;
  } cdb_packet_t;
  typedef struct packed {
    logic [ROB_W-1:0] robn;
    logic             executed;
    logic             branch_taken;
    logic [XLEN-1:0]  target_addr;
  } fu_rob_packet_t;
  localparam int REQ_W     = $bits(cdb_req_packet_t);
  localparam int CDB_W     = $bits(cdb_packet_t);
  localparam int ROB_PKT_W = $bits(fu_rob_packet_t);
  // Index width that stays at least one bit wide for single-entry structures.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_grant.sv
// rr_multi_grant: round-robin scan granting up to popcount(port_enable) requesters
// Ports: i_req (nonempty queues), i_rr_ptr (scan start), i_port_enable (usable ports),
//   o_port_grant (one-hot source per port), o_src_grant (granted sources),
//   o_next_rr_ptr (one past the last winner, or i_rr_ptr when nothing is granted).
module rr_multi_grant import cdb_arbiter_rr_pkg::*; #(
  parameter  int NUM_SRC   = 4,
  parameter  int NUM_PORTS = 2,
  localparam int PTR_W     = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]                  i_req,
  input  logic [PTR_W-1:0]                    i_rr_ptr,
  input  logic [NUM_PORTS-1:0]                i_port_enable,
  output logic [NUM_PORTS-1:0][NUM_SRC-1:0]   o_port_grant,
  output logic [NUM_SRC-1:0]                  o_src_grant,
  output logic [PTR_W-1:0]                    o_next_rr_ptr
);
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  int               w_seen;
  int               w_rank;
  // The n-th requester met in scan order is paired with the n-th enabled port;
  // requesters beyond the enabled-port count find no matching rank and lose.
  always_comb begin
    o_port_grant  = '0;
    o_src_grant   = '0;
    o_next_rr_ptr = i_rr_ptr;
    w_sum         = '0;
    w_idx         = '0;
    w_seen        = 0;
    w_rank        = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (PTR_W+1)'(k);
      w_idx = (w_sum >= (PTR_W+1)'(NUM_SRC)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_SRC)) : PTR_W'(w_sum);
      if (i_req[w_idx]) begin
        w_rank = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (i_port_enable[j]) begin
            if (w_rank == w_seen) begin
              o_port_grant[j][w_idx] = 1'b1;
              o_src_grant[w_idx]     = 1'b1;
              o_next_rr_ptr          = (w_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_idx + PTR_W'(1);
            end
            w_rank++;
          end
        end
        w_seen++;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter_rr.sv
// cdb_arbiter_rr: per-source result FIFOs feeding a multi-port round-robin completion bus
// Ports: clock/reset (sync, active-high); src_valid/src_packet/src_ready per FU source;
//   port_enable masks broadcast ports; squash flushes every queue;
//   cdb_valid/cdb_output to PRF and RS, fu_rob_packet to ROB; occupancy per queue.
module cdb_arbiter_rr import cdb_arbiter_rr_pkg::*; #(
  parameter  int NUM_SRC   = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD,
  parameter  int NUM_PORTS = N,
  parameter  int QDEPTH    = CDB_QDEPTH,
  localparam int PTR_W     = clog2_min1(NUM_SRC),
  localparam int AW        = clog2_min1(QDEPTH),
  localparam int CW        = $clog2(QDEPTH + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC-1:0][REQ_W-1:0]       src_packet,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_PORTS-1:0]                port_enable,
  input  logic                                squash,
  output logic [NUM_PORTS-1:0]                cdb_valid,
  output logic [NUM_PORTS-1:0][CDB_W-1:0]     cdb_output,
  output logic [NUM_PORTS-1:0][ROB_PKT_W-1:0] fu_rob_packet,
  output logic [NUM_SRC-1:0][CW-1:0]          occupancy
);
  cdb_req_packet_t                     r_mem [NUM_SRC][QDEPTH];
  logic [AW-1:0]                       r_head [NUM_SRC];
  logic [AW-1:0]                       r_tail [NUM_SRC];
  logic [CW-1:0]                       r_count [NUM_SRC];
  logic [PTR_W-1:0]                    r_rr_ptr;
  logic [NUM_SRC-1:0]                  w_req;
  logic [NUM_SRC-1:0]                  w_push;
  logic [NUM_SRC-1:0]                  w_grant;
  logic [PTR_W-1:0]                    w_next_rr;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0]   w_port_grant;
  cdb_req_packet_t                     w_head_pkt [NUM_SRC];
  cdb_req_packet_t                     w_sel [NUM_PORTS];
  // Requests are masked in squash and reset cycles, which suppresses every grant,
  // every pop and any rr_ptr movement without a separate override path.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_req[i]      = (r_count[i] != '0) && !squash && !reset;
      src_ready[i]  = (r_count[i] < CW'(QDEPTH)) && !squash && !reset;
      w_push[i]     = src_valid[i] && src_ready[i];
      w_head_pkt[i] = r_mem[i][r_head[i]];
      occupancy[i]  = r_count[i];
    end
  end
  rr_multi_grant #(
    .NUM_SRC   (NUM_SRC),
    .NUM_PORTS (NUM_PORTS)
  ) u_grant (
    .i_req         (w_req),
    .i_rr_ptr      (r_rr_ptr),
    .i_port_enable (port_enable),
    .o_port_grant  (w_port_grant),
    .o_src_grant   (w_grant),
    .o_next_rr_ptr (w_next_rr)
  );
  // AND-OR one-hot select: an ungranted port ORs nothing and so drives zeros.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_sel[j] = '0;
      for (int i = 0; i < NUM_SRC; i++) w_sel[j] = w_sel[j] | ({REQ_W{w_port_grant[j][i]}} & w_head_pkt[i]);
      cdb_valid[j]     = |w_port_grant[j];
      cdb_output[j]    = {w_sel[j].dest_prn, w_sel[j].value};
      fu_rob_packet[j] = {w_sel[j].robn, cdb_valid[j], w_sel[j].take_branch, w_sel[j].target_addr};
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) if (w_push[i]) r_mem[i][r_tail[i]] <= cdb_req_packet_t'(src_packet[i]);
  end
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) r_tail[i] <= (r_tail[i] == AW'(QDEPTH - 1)) ? '0 : r_tail[i] + AW'(1);
        if (w_grant[i]) r_head[i] <= (r_head[i] == AW'(QDEPTH - 1)) ? '0 : r_head[i] + AW'(1);
        r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_grant[i]);
      end
      r_rr_ptr <= w_next_rr;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// tb_cdb_arbiter_rr: scoreboard bench comparing the completion bus with a queue-level reference model
module tb_cdb_arbiter_rr;
  import cdb_arbiter_rr_pkg::*;
  localparam int NS = 4;
  localparam int NP = 2;
  localparam int QD = 2;
  localparam int CW = $clog2(QD + 1);
  typedef struct packed {
    logic [NP-1:0]                v;
    logic [NP-1:0][CDB_W-1:0]     co;
    logic [NP-1:0][ROB_PKT_W-1:0] ro;
    logic [NS-1:0]                rdy;
    logic [NS-1:0][CW-1:0]        occ;
  } exp_t;
  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic                         squash = 1'b0;
  logic [NS-1:0]                src_valid = '0;
  logic [NS-1:0][REQ_W-1:0]     src_packet = '0;
  logic [NP-1:0]                port_enable = '0;
  logic [NS-1:0]                src_ready;
  logic [NP-1:0]                cdb_valid;
  logic [NP-1:0][CDB_W-1:0]     cdb_output;
  logic [NP-1:0][ROB_PKT_W-1:0] fu_rob_packet;
  logic [NS-1:0][CW-1:0]        occupancy;
  exp_t                         exp_q[$];
  exp_t                         me;
  cdb_req_packet_t              mq[NS][$];
  cdb_req_packet_t              pk_in[NS];
  int                           rr_m = 0;
  int                           n_chk = 0;
  int                           n_pass = 0;
  cdb_arbiter_rr #(.NUM_SRC(NS), .NUM_PORTS(NP), .QDEPTH(QD)) dut (
    .clock         (clock),
    .reset         (reset),
    .src_valid     (src_valid),
    .src_packet    (src_packet),
    .src_ready     (src_ready),
    .port_enable   (port_enable),
    .squash        (squash),
    .cdb_valid     (cdb_valid),
    .cdb_output    (cdb_output),
    .fu_rob_packet (fu_rob_packet),
    .occupancy     (occupancy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic rand_pkts();
    for (int i = 0; i < NS; i++) begin
      pk_in[i].robn        = ROB_W'($urandom);
      pk_in[i].dest_prn    = PRN_W'($urandom);
      pk_in[i].value       = $urandom;
      pk_in[i].take_branch = 1'($urandom);
      pk_in[i].target_addr = $urandom;
    end
  endtask
  // Model: plain packet queues per source; each cycle the nonempty queues are
  // listed in scan order from rr_m and zipped with the ascending enabled ports.
  task automatic step(input logic [NS-1:0] v, input logic [NP-1:0] en, input logic sq, input logic rst);
    exp_t           e;
    int             cands[$];
    int             ports[$];
    int             ng;
    int             last;
    logic [NS-1:0]  g;
    cdb_packet_t    c;
    fu_rob_packet_t r;
    @(negedge clock);
    src_valid   = v;
    port_enable = en;
    squash      = sq;
    reset       = rst;
    for (int i = 0; i < NS; i++) src_packet[i] = pk_in[i];
    e    = '0;
    g    = '0;
    last = rr_m;
    for (int k = 0; k < NS; k++) begin
      int s;
      s = (rr_m + k) % NS;
      if (!sq && !rst && mq[s].size() > 0) cands.push_back(s);
    end
    for (int p = 0; p < NP; p++) if (en[p]) ports.push_back(p);
    ng = (cands.size() < ports.size()) ? cands.size() : ports.size();
    for (int n = 0; n < ng; n++) begin
      int s;
      int p;
      s              = cands[n];
      p              = ports[n];
      c.dest_prn     = mq[s][0].dest_prn;
      c.value        = mq[s][0].value;
      r.robn         = mq[s][0].robn;
      r.executed     = 1'b1;
      r.branch_taken = mq[s][0].take_branch;
      r.target_addr  = mq[s][0].target_addr;
      e.v[p]         = 1'b1;
      e.co[p]        = c;
      e.ro[p]        = r;
      g[s]           = 1'b1;
      last           = s;
    end
    for (int i = 0; i < NS; i++) begin
      e.rdy[i] = !rst && !sq && (mq[i].size() < QD);
      e.occ[i] = CW'(mq[i].size());
    end
    exp_q.push_back(e);
    if (rst || sq) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      rr_m = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (g[i]) void'(mq[i].pop_front());
        if (v[i] && e.rdy[i]) mq[i].push_back(pk_in[i]);
      end
      if (ng > 0) rr_m = (last + 1) % NS;
    end
  endtask
  task automatic rstep(input logic [NS-1:0] v, input logic [NP-1:0] en, input logic sq, input logic rst);
    rand_pkts();
    step(v, en, sq, rst);
  endtask
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("cdb_valid", 128'(cdb_valid), 128'(me.v));
        chk("cdb_output", 128'(cdb_output), 128'(me.co));
        chk("fu_rob_packet", 128'(fu_rob_packet), 128'(me.ro));
        chk("src_ready", 128'(src_ready), 128'(me.rdy));
        chk("occupancy", 128'(occupancy), 128'(me.occ));
      end
    end
  end
  initial begin
    cdb_packet_t    xc;
    fu_rob_packet_t xr;
    rand_pkts();
    repeat (2) @(posedge clock);
    rstep(4'h0, 2'b11, 1'b0, 1'b1);
    // all four sources valid at once: 0,1 then 2,3
    rstep(4'hF, 2'b11, 1'b0, 1'b0);
    rstep(4'h0, 2'b11, 1'b0, 1'b0);
    #2;
    chk("first_pair_valid", 128'(cdb_valid), 128'(2'b11));
    rstep(4'h0, 2'b11, 1'b0, 1'b0);
    rstep(4'h0, 2'b11, 1'b0, 1'b0);
    // single port, everyone busy: starvation freedom and full-queue behaviour
    for (int t = 0; t < 16; t++) rstep(4'hF, 2'b01, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) rstep(4'h0, 2'b11, 1'b0, 1'b0);
    // three queued packets, then squash with new inputs
    rstep(4'b0111, 2'b00, 1'b0, 1'b0);
    rstep(4'hF, 2'b11, 1'b1, 1'b0);
    #2;
    chk("squash_cycle_valid", 128'(cdb_valid), 128'(0));
    rstep(4'h0, 2'b11, 1'b0, 1'b0);
    #2;
    chk("post_squash_occ", 128'(occupancy), 128'(0));
    chk("post_squash_valid", 128'(cdb_valid), 128'(0));
    // a known packet routed to port 1 only
    rand_pkts();
    pk_in[0]             = '0;
    pk_in[0].robn        = ROB_W'(3);
    pk_in[0].dest_prn    = PRN_W'(5);
    pk_in[0].value       = 32'hDEAD;
    step(4'b0001, 2'b00, 1'b0, 1'b0);
    rstep(4'h0, 2'b10, 1'b0, 1'b0);
    #2;
    xc          = '0;
    xc.dest_prn = PRN_W'(5);
    xc.value    = 32'hDEAD;
    xr          = '0;
    xr.robn     = ROB_W'(3);
    xr.executed = 1'b1;
    chk("pe10_valid", 128'(cdb_valid), 128'(2'b10));
    chk("pe10_port0_cdb", 128'(cdb_output[0]), 128'(0));
    chk("pe10_port0_rob", 128'(fu_rob_packet[0]), 128'(0));
    chk("pe10_port1_cdb", 128'(cdb_output[1]), 128'(xc));
    chk("pe10_port1_rob", 128'(fu_rob_packet[1]), 128'(xr));
    // reset in the middle of traffic
    rstep(4'hF, 2'b00, 1'b0, 1'b0);
    rstep(4'hF, 2'b01, 1'b0, 1'b0);
    rstep(4'hF, 2'b11, 1'b0, 1'b1);
    rstep(4'hF, 2'b11, 1'b0, 1'b1);
    #2;
    chk("reset_occ", 128'(occupancy), 128'(0));
    chk("reset_valid", 128'(cdb_valid), 128'(0));
    rstep(4'h0, 2'b11, 1'b0, 1'b0);
    #2;
    chk("ready_after_reset", 128'(src_ready), 128'(4'hF));
    // randomized traffic with occasional squash and reset
    for (int t = 0; t < 400; t++)
      rstep(NS'($urandom), NP'($urandom), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clock);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter_rr.md
Name: cdb_arbiter_rr

Overview:
Parametrised completion bus for the out-of-order core. Replaces the single-entry, fixed-priority CDB stage with a per-source FIFO of configurable depth and a round-robin arbiter that drives a configurable number of broadcast ports. A per-port enable mask supports degraded-width modes, and a squash input supports branch-mispredict recovery. Sits between the functional units and the PRF, RS wakeup and ROB completion logic.

Parameters:
- NUM_SRC, default `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LOAD: number of requesting FU outputs.
- NUM_PORTS, default `N: number of broadcast ports.
- QDEPTH, default 2: entries per source FIFO; must be at least 1.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- src_valid  in  NUM_SRC  FU result valid, one bit per source.
- src_packet  in  NUM_SRC x CDB_REQ_PACKET  fields: robn, dest_prn, value, take_branch, target_addr.
- src_ready  out  NUM_SRC  FIFO can accept a packet this cycle.
- port_enable  in  NUM_PORTS  per-port enable mask; a disabled port never carries a grant.
- squash  in  1  flush all queued results.
- cdb_valid  out  NUM_PORTS  port carries a valid broadcast this cycle.
- cdb_output  out  NUM_PORTS x CDB_PACKET  {dest_prn, value} to PRF and RS.
- fu_rob_packet  out  NUM_PORTS x FU_ROB_PACKET  {robn, executed, branch_taken, target_addr} to ROB.
- occupancy  out  NUM_SRC x $clog2(QDEPTH+1)  per-queue entry count, for debug and perf.

Behaviour:
- Queues:
  - Each source has a FIFO with a head pointer, a tail pointer and a count. Pointers wrap modulo QDEPTH.
  - src_ready[i] = (count[i] < QDEPTH) && !squash. It depends on registered state only; there is no combinational path from the grant.
  - Push occurs when src_valid[i] && src_ready[i]. When src_valid is low, src_packet is ignored.
  - Pop occurs when the head of queue i is granted.
  - Push and pop in the same cycle leave count unchanged. A full queue cannot push, even if its head is popped in that cycle.
- Arbitration (combinational, from registered state):
  - Candidates are the queues with count > 0.
  - Scan candidates starting at rr_ptr and wrapping modulo NUM_SRC. Grant the first E of them, where E = popcount(port_enable).
  - The k-th grant in scan order goes to the k-th enabled port, with ports taken in ascending index order.
  - Each queue receives at most one grant per cycle.
- Priority pointer:
  - If any grant is made, rr_ptr <= (index of the last granted source + 1) mod NUM_SRC.
  - If no grant is made, rr_ptr is unchanged.
- Outputs:
  - A granted port drives the queue head: cdb_valid = 1, cdb_output = {dest_prn, value}, fu_rob_packet = {robn, 1, take_branch, target_addr}.
  - An ungranted or disabled port drives all-zero cdb_output, all-zero fu_rob_packet and cdb_valid = 0.
- Latency: a packet pushed in cycle t is broadcast no earlier than cycle t+1. It broadcasts exactly at t+1 when its queue was empty and ports are free.
- Squash:
  - In the squash cycle, all cdb_valid are forced to 0 and no pops occur. src_ready is 0, so inputs are dropped.
  - At the next edge, every count, head and tail pointer clears and rr_ptr is set to 0.
  - Squash asserted in consecutive cycles holds the empty state.
- Reset:
  - Every count, head and tail pointer is 0 and rr_ptr is 0.
  - All outputs are 0, except src_ready, which is all 1s after reset deasserts.
  - Reset takes priority over squash and over push/pop. Reset during operation discards all queued packets.
- Boundaries:
  - port_enable = 0: no grants and no rr_ptr change; queues fill, then src_ready drops.
  - More nonempty queues than enabled ports: the lowest scan-order sources win, and rr_ptr moves past the last winner. This guarantees starvation freedom.

Decomposition:
- Shared package (sys_defs):
  - CDB_REQ_PACKET typedef.
  - existing CDB_PACKET and FU_ROB_PACKET typedefs.
  - new define `CDB_QDEPTH.
- Sub-module rr_multi_grant (NUM_SRC, NUM_PORTS):
  - inputs: req vector, rr_ptr, port_enable.
  - outputs: per-port one-hot grant bus, per-source grant vector, next rr_ptr.
  - Output muxing reuses the existing onehot_mux.

Test Plan:
- NUM_SRC=4, NUM_PORTS=2, QDEPTH=2, reset, then all four sources valid in cycle 0:
  - cycle 1: sources 0 and 1 on ports 0 and 1, rr_ptr becomes 2.
  - cycle 2: sources 2 and 3 broadcast.
- Source 0 pushes every cycle while only port 0 is enabled and sources 1–3 are continuously busy:
  - source 0 is granted once every 4 cycles, proving no starvation.
  - its occupancy reaches 2 and src_ready[0] drops to 0.
- Full queue, head granted, src_valid=1 in the same cycle:
  - no push occurs; count goes 2 to 1; src_ready returns to 1 the next cycle.
- Squash asserted with 3 queued packets and src_valid=1:
  - cdb_valid = 0 in that cycle.
  - next cycle: all occupancy = 0 and rr_ptr = 0; the dropped packet never appears.
- port_enable = 2'b10 with one packet {prn=5, value=0xDEAD, robn=3}:
  - appears on port 1; port 0 drives zeros with cdb_valid[0] = 0.
- Reset asserted mid-stream with queues partially full:
  - next cycle: all outputs zero and all occupancy 0; after release, src_ready is all 1s.
